// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer for the 8259 core.
// Decodes INTA# pulse trains (8086 two-pulse, 8080 three-pulse), drives the
// vector / CALL bytes, pulses the in-service latch, and applies OCW2 EOI and
// rotate commands together with automatic EOI at the end of acknowledge.
module interrupt_ack_sequencer #(
  parameter logic [7:0] CALL_OPCODE  = 8'hCD,
  parameter logic [2:0] RESET_ROTATE = 3'd7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic [7:0] interrupt_request_resolved,
  input  logic [7:0] highest_level_in_service,
  input  logic       mode_8086,
  input  logic       auto_eoi,
  input  logic       call_interval_4,
  input  logic [4:0] vector_base,
  input  logic [7:0] call_address_low,
  input  logic [7:0] call_address_high,
  input  logic       ocw2_write,
  input  logic [2:0] ocw2_command,
  input  logic [2:0] ocw2_level,
  output logic       latch_in_service,
  output logic [7:0] interrupt_to_latch,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic [7:0] vector_out,
  output logic       vector_out_enable
);

  typedef enum logic [1:0] {IDLE, ACK1, ACK2, ACK3} state_t;

  state_t     state;
  state_t     next_state;
  logic       inta_prev;
  logic       fall;
  logic       rise;

  logic       mode_held;
  logic       aeoi_held;
  logic       interval_held;
  logic [2:0] level_held;
  logic       spurious_held;
  logic       rotate_on_aeoi;

  logic [2:0] resolved_level;
  logic       cur_mode;
  logic [2:0] cur_level;
  logic       drive_next;
  logic [7:0] byte_next;

  logic       end_of_ack;
  logic       aeoi_event;
  logic [7:0] aeoi_mask;

  logic [7:0] ocw2_eoi_mask;
  logic       ocw2_rotate_valid;
  logic [2:0] ocw2_rotate_value;
  logic       ocw2_set_raeoi;
  logic       ocw2_clr_raeoi;

  // Low address bits below A5 never reach the data bus in either interval.
  logic       addr_low_unused;
  assign addr_low_unused = ^call_address_low[4:0];

  function automatic logic [2:0] encode8(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] decode8(input logic [2:0] level);
    return 8'b1 << level;
  endfunction

  assign fall = inta_prev & ~interrupt_acknowledge_n;
  assign rise = ~inta_prev & interrupt_acknowledge_n;

  // Level and mode seen by the byte mux: live inputs at the first fall, held copies afterwards.
  always_comb begin
    resolved_level = (interrupt_request_resolved == 8'h00) ? 3'd7
                                                           : encode8(interrupt_request_resolved);
    cur_mode  = (state == IDLE) ? mode_8086 : mode_held;
    cur_level = (state == IDLE) ? resolved_level : level_held;
  end

  // Acknowledge sequencing: only falls advance, except the closing rise of the last byte.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (fall) next_state = ACK1;
      ACK1: if (fall) next_state = ACK2;
      ACK2: begin
        if (mode_held) begin
          if (rise) next_state = IDLE;
        end else if (fall) begin
          next_state = ACK3;
        end
      end
      ACK3: if (rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Byte to place on the bus next cycle while INTA# stays low in a driving state.
  always_comb begin
    drive_next = 1'b0;
    byte_next  = 8'h00;
    if (!interrupt_acknowledge_n) begin
      unique case (next_state)
        IDLE: begin
          drive_next = 1'b0;
        end
        ACK1: begin
          if (!cur_mode) begin
            drive_next = 1'b1;
            byte_next  = CALL_OPCODE;
          end
        end
        ACK2: begin
          drive_next = 1'b1;
          if (cur_mode)
            byte_next = {vector_base, cur_level};
          else if (interval_held)
            byte_next = {call_address_low[7:5], cur_level, 2'b00};
          else
            byte_next = {call_address_low[7:6], cur_level, 3'b000};
        end
        ACK3: begin
          drive_next = 1'b1;
          byte_next  = call_address_high;
        end
        default: drive_next = 1'b0;
      endcase
    end
  end

  // Automatic EOI fires on the rise that closes the last byte of a real acknowledge.
  always_comb begin
    end_of_ack = rise && (((state == ACK2) && mode_held) || (state == ACK3));
    aeoi_event = end_of_ack && aeoi_held && !spurious_held;
    aeoi_mask  = aeoi_event ? decode8(level_held) : 8'h00;
  end

  // OCW2 command decode into an EOI mask, an optional new rotate value and AEOI-rotate control.
  always_comb begin
    ocw2_eoi_mask     = 8'h00;
    ocw2_rotate_valid = 1'b0;
    ocw2_rotate_value = priority_rotate;
    ocw2_set_raeoi    = 1'b0;
    ocw2_clr_raeoi    = 1'b0;
    if (ocw2_write) begin
      unique case (ocw2_command)
        3'b001: ocw2_eoi_mask = highest_level_in_service;
        3'b011: ocw2_eoi_mask = decode8(ocw2_level);
        3'b101: begin
          ocw2_eoi_mask = highest_level_in_service;
          if (highest_level_in_service != 8'h00) begin
            ocw2_rotate_valid = 1'b1;
            ocw2_rotate_value = encode8(highest_level_in_service);
          end
        end
        3'b111: begin
          ocw2_eoi_mask     = decode8(ocw2_level);
          ocw2_rotate_valid = 1'b1;
          ocw2_rotate_value = ocw2_level;
        end
        3'b110: begin
          ocw2_rotate_valid = 1'b1;
          ocw2_rotate_value = ocw2_level;
        end
        3'b100:  ocw2_set_raeoi = 1'b1;
        3'b000:  ocw2_clr_raeoi = 1'b1;
        default: ocw2_eoi_mask  = 8'h00;
      endcase
    end
  end

  // State, captured sequence context and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      inta_prev          <= 1'b1;
      mode_held          <= 1'b0;
      aeoi_held          <= 1'b0;
      interval_held      <= 1'b0;
      level_held         <= 3'd0;
      spurious_held      <= 1'b0;
      rotate_on_aeoi     <= 1'b0;
      latch_in_service   <= 1'b0;
      interrupt_to_latch <= 8'h00;
      end_of_interrupt   <= 8'h00;
      priority_rotate    <= RESET_ROTATE;
      vector_out         <= 8'h00;
      vector_out_enable  <= 1'b0;
    end else begin
      inta_prev         <= interrupt_acknowledge_n;
      state             <= next_state;
      vector_out_enable <= drive_next;
      vector_out        <= byte_next;
      latch_in_service  <= (state == IDLE) && fall && (interrupt_request_resolved != 8'h00);
      if ((state == IDLE) && fall) begin
        mode_held     <= mode_8086;
        aeoi_held     <= auto_eoi;
        interval_held <= call_interval_4;
        level_held    <= resolved_level;
        spurious_held <= (interrupt_request_resolved == 8'h00);
        if (interrupt_request_resolved != 8'h00)
          interrupt_to_latch <= interrupt_request_resolved;
      end
      end_of_interrupt <= aeoi_mask | ocw2_eoi_mask;
      if (ocw2_rotate_valid)
        priority_rotate <= ocw2_rotate_value;
      else if (aeoi_event && rotate_on_aeoi)
        priority_rotate <= level_held;
      if (ocw2_set_raeoi)
        rotate_on_aeoi <= 1'b1;
      else if (ocw2_clr_raeoi)
        rotate_on_aeoi <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed testbench for interrupt_ack_sequencer: 8086/8080 acknowledge,
// AEOI with rotation, spurious requests, OCW2 commands and mid-sequence reset.
module tb_interrupt_ack_sequencer;

  logic       clock;
  logic       reset;
  logic       interrupt_acknowledge_n;
  logic [7:0] interrupt_request_resolved;
  logic [7:0] highest_level_in_service;
  logic       mode_8086;
  logic       auto_eoi;
  logic       call_interval_4;
  logic [4:0] vector_base;
  logic [7:0] call_address_low;
  logic [7:0] call_address_high;
  logic       ocw2_write;
  logic [2:0] ocw2_command;
  logic [2:0] ocw2_level;
  logic       latch_in_service;
  logic [7:0] interrupt_to_latch;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [7:0] vector_out;
  logic       vector_out_enable;

  int vectors;
  int miscompares;

  interrupt_ack_sequencer dut (
    .clock                      (clock),
    .reset                      (reset),
    .interrupt_acknowledge_n    (interrupt_acknowledge_n),
    .interrupt_request_resolved (interrupt_request_resolved),
    .highest_level_in_service   (highest_level_in_service),
    .mode_8086                  (mode_8086),
    .auto_eoi                   (auto_eoi),
    .call_interval_4            (call_interval_4),
    .vector_base                (vector_base),
    .call_address_low           (call_address_low),
    .call_address_high          (call_address_high),
    .ocw2_write                 (ocw2_write),
    .ocw2_command               (ocw2_command),
    .ocw2_level                 (ocw2_level),
    .latch_in_service           (latch_in_service),
    .interrupt_to_latch         (interrupt_to_latch),
    .end_of_interrupt           (end_of_interrupt),
    .priority_rotate            (priority_rotate),
    .vector_out                 (vector_out),
    .vector_out_enable          (vector_out_enable)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic inta_level);
    interrupt_acknowledge_n = inta_level;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic writeOcw2(input logic [2:0] cmd, input logic [2:0] lvl);
    ocw2_write   = 1'b1;
    ocw2_command = cmd;
    ocw2_level   = lvl;
    tick();
    ocw2_write   = 1'b0;
  endtask

  // Linear sequence of directed steps.
  initial begin
    vectors                    = 0;
    miscompares                = 0;
    reset                      = 1'b1;
    interrupt_acknowledge_n    = 1'b1;
    interrupt_request_resolved = 8'h00;
    highest_level_in_service   = 8'h00;
    mode_8086                  = 1'b1;
    auto_eoi                   = 1'b0;
    call_interval_4            = 1'b0;
    vector_base                = 5'b00000;
    call_address_low           = 8'h00;
    call_address_high          = 8'h00;
    ocw2_write                 = 1'b0;
    ocw2_command               = 3'b000;
    ocw2_level                 = 3'd0;
    tick(3);
    checkOutput("reset_rotate", {5'b0, priority_rotate}, 8'h07);
    checkOutput("reset_enable", {7'b0, vector_out_enable}, 8'h00);
    checkOutput("reset_latch", {7'b0, latch_in_service}, 8'h00);
    checkOutput("reset_eoi", end_of_interrupt, 8'h00);
    checkOutput("reset_vector", vector_out, 8'h00);
    reset = 1'b0;
    tick();

    $display("[TB] 8086 acknowledge");
    mode_8086 = 1'b1;
    interrupt_request_resolved = 8'h08;
    vector_base = 5'b01000;
    applyStimulus(1'b0);
    checkOutput("t1_latch", {7'b0, latch_in_service}, 8'h01);
    checkOutput("t1_to_latch", interrupt_to_latch, 8'h08);
    checkOutput("t1_ack1_enable", {7'b0, vector_out_enable}, 8'h00);
    tick();
    checkOutput("t1_latch_one_cycle", {7'b0, latch_in_service}, 8'h00);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("t1_vector", vector_out, 8'h43);
    checkOutput("t1_enable_low", {7'b0, vector_out_enable}, 8'h01);
    applyStimulus(1'b1);
    checkOutput("t1_enable_after_rise", {7'b0, vector_out_enable}, 8'h00);
    checkOutput("t1_no_eoi", end_of_interrupt, 8'h00);
    tick();

    $display("[TB] 8080 acknowledge interval 4");
    mode_8086 = 1'b0;
    call_interval_4 = 1'b1;
    interrupt_request_resolved = 8'h20;
    call_address_low = 8'hE0;
    call_address_high = 8'h12;
    applyStimulus(1'b0);
    checkOutput("t2_call_byte", vector_out, 8'hCD);
    checkOutput("t2_call_enable", {7'b0, vector_out_enable}, 8'h01);
    checkOutput("t2_to_latch", interrupt_to_latch, 8'h20);
    applyStimulus(1'b1);
    checkOutput("t2_gap1_enable", {7'b0, vector_out_enable}, 8'h00);
    applyStimulus(1'b0);
    checkOutput("t2_low_byte", vector_out, 8'hF4);
    applyStimulus(1'b1);
    checkOutput("t2_gap2_enable", {7'b0, vector_out_enable}, 8'h00);
    applyStimulus(1'b0);
    checkOutput("t2_high_byte", vector_out, 8'h12);
    applyStimulus(1'b1);
    checkOutput("t2_end_enable", {7'b0, vector_out_enable}, 8'h00);
    tick();

    $display("[TB] AEOI with rotate");
    writeOcw2(3'b100, 3'd0);
    tick();
    mode_8086 = 1'b1;
    auto_eoi = 1'b1;
    vector_base = 5'b00000;
    interrupt_request_resolved = 8'h04;
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("t3_vector", vector_out, 8'h02);
    checkOutput("t3_no_early_eoi", end_of_interrupt, 8'h00);
    applyStimulus(1'b1);
    checkOutput("t3_aeoi_mask", end_of_interrupt, 8'h04);
    checkOutput("t3_rotate", {5'b0, priority_rotate}, 8'h02);
    tick();
    checkOutput("t3_aeoi_one_cycle", end_of_interrupt, 8'h00);
    writeOcw2(3'b000, 3'd0);
    tick();

    $display("[TB] spurious request");
    interrupt_request_resolved = 8'h00;
    vector_base = 5'b00001;
    applyStimulus(1'b0);
    checkOutput("t4_no_latch", {7'b0, latch_in_service}, 8'h00);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("t4_vector", vector_out, 8'h0F);
    applyStimulus(1'b1);
    checkOutput("t4_no_aeoi", end_of_interrupt, 8'h00);
    checkOutput("t4_rotate_kept", {5'b0, priority_rotate}, 8'h02);
    auto_eoi = 1'b0;
    tick();

    $display("[TB] OCW2 commands");
    highest_level_in_service = 8'h10;
    writeOcw2(3'b101, 3'd0);
    checkOutput("t5_rot_ns_eoi", end_of_interrupt, 8'h10);
    checkOutput("t5_rot_ns_rotate", {5'b0, priority_rotate}, 8'h04);
    writeOcw2(3'b110, 3'd5);
    checkOutput("t5_setpri_eoi", end_of_interrupt, 8'h00);
    checkOutput("t5_setpri_rotate", {5'b0, priority_rotate}, 8'h05);
    highest_level_in_service = 8'h00;
    writeOcw2(3'b001, 3'd0);
    checkOutput("t5_ns_eoi_empty", end_of_interrupt, 8'h00);
    writeOcw2(3'b011, 3'd6);
    checkOutput("t5_spec_eoi", end_of_interrupt, 8'h40);
    checkOutput("t5_spec_eoi_rotate", {5'b0, priority_rotate}, 8'h05);
    writeOcw2(3'b111, 3'd3);
    checkOutput("t5_rot_spec_eoi", end_of_interrupt, 8'h08);
    checkOutput("t5_rot_spec_rotate", {5'b0, priority_rotate}, 8'h03);
    writeOcw2(3'b101, 3'd0);
    checkOutput("t5_rot_ns_empty", {5'b0, priority_rotate}, 8'h03);
    tick();

    $display("[TB] simultaneous AEOI and OCW2");
    writeOcw2(3'b100, 3'd0);
    tick();
    auto_eoi = 1'b1;
    mode_8086 = 1'b1;
    vector_base = 5'b00000;
    interrupt_request_resolved = 8'h01;
    applyStimulus(1'b0);
    checkOutput("t7_to_latch", interrupt_to_latch, 8'h01);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("t7_enable", {7'b0, vector_out_enable}, 8'h01);
    ocw2_write = 1'b1;
    ocw2_command = 3'b111;
    ocw2_level = 3'd6;
    applyStimulus(1'b1);
    ocw2_write = 1'b0;
    checkOutput("t7_or_mask", end_of_interrupt, 8'h41);
    checkOutput("t7_ocw2_rotate_wins", {5'b0, priority_rotate}, 8'h06);
    writeOcw2(3'b000, 3'd0);
    auto_eoi = 1'b0;
    tick();

    $display("[TB] reset mid-sequence");
    mode_8086 = 1'b0;
    call_interval_4 = 1'b0;
    call_address_low = 8'h00;
    interrupt_request_resolved = 8'h02;
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("t6_ack2_byte", vector_out, 8'h08);
    reset = 1'b1;
    tick();
    checkOutput("t6_reset_enable", {7'b0, vector_out_enable}, 8'h00);
    checkOutput("t6_reset_rotate", {5'b0, priority_rotate}, 8'h07);
    checkOutput("t6_reset_vector", vector_out, 8'h00);
    interrupt_acknowledge_n = 1'b1;
    reset = 1'b0;
    tick();
    applyStimulus(1'b0);
    checkOutput("t6_restart_call", vector_out, 8'hCD);
    checkOutput("t6_restart_latch", {7'b0, latch_in_service}, 8'h01);
    applyStimulus(1'b1);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
